fdd_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of dual-edge-triggered flip-flops (CE/I/SET/RST style cells) between NREQ requesters.
- Each requester asks for one operation: load data, set all bits, clear all bits, or no-op.
- The block drives the bank's CE, I, SET and RST pins, and enforces a recovery gap after SET/RST before CE can be asserted again.
- Sits between bus-side requesters and the register bank in the lab datapath.

---
 rtl/fdd_bank_arbiter_if.sv | 27 ++
 rtl/fdd_bank_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fdd_bank_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fdd_bank_arbiter_if.sv
// Requester/bank bundle for fdd_bank_arbiter: requests in, grants/acks and bank pins out.
// slave = arbiter side, master = requester/bank side.
interface fdd_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic                  bank_ce;
    logic [WIDTH-1:0]      bank_d;
    logic                  bank_set;
    logic                  bank_rst;

    modport slave (
        input  req, op, wdata,
        output gnt, ack, busy, bank_ce, bank_d, bank_set, bank_rst
    );

    modport master (
        output req, op, wdata,
        input  gnt, ack, busy, bank_ce, bank_d, bank_set, bank_rst
    );
endinterface

// File: rtl/fdd_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one CE/I/SET/RST flip-flop bank between NREQ requesters.
// Optional macro FDD_ARB_PRIO0_EN: requester 0 gets fixed top priority over the round-robin.
module fdd_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int RECOV_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fdd_bank_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RECOV = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [IW-1:0]    last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             ce_q, ce_d;
    logic             set_q, set_d;
    logic             rst_q, rst_d;
    logic [WIDTH-1:0] bank_d_q, bank_d_d;

    // Per-requester views of the flattened op/data buses.
    logic [1:0]       op_arr   [NREQ];
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]   = bus.op[2*gi +: 2];
        assign data_arr[gi] = bus.wdata[WIDTH*gi +: WIDTH];
    end

    logic [NREQ-1:0] req_rr;
    logic            found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            win_prio0;

    // Search last+1, last+2, ... modulo NREQ; the first active request wins.
    always_comb begin
        req_rr    = bus.req;
        found     = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_prio0 = 1'b0;
`ifdef FDD_ARB_PRIO0_EN
        req_rr[0] = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!found && req_rr[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`ifdef FDD_ARB_PRIO0_EN
        if (bus.req[0]) begin
            found     = 1'b1;
            win_idx   = '0;
            win_prio0 = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        ce_d     = 1'b0;
        set_d    = 1'b0;
        rst_d    = 1'b0;
        bank_d_d = bank_d_q;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = ST_DRIVE;
                    op_d    = op_arr[win_idx];
                    gnt_d   = NREQ'(1) << win_idx;
                    ack_d   = NREQ'(1) << win_idx;
                    if (!win_prio0) begin
                        last_d = win_idx;
                    end
                    // Bank pins are registered, so they assert in the DRIVE cycle with ack.
                    case (op_arr[win_idx])
                        OP_LOAD: begin
                            ce_d     = 1'b1;
                            bank_d_d = data_arr[win_idx];
                        end
                        OP_SET:  set_d = 1'b1;
                        OP_CLR:  rst_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_DRIVE: begin
                if (op_q == OP_SET || op_q == OP_CLR) begin
                    state_d = ST_RECOV;
                    cnt_d   = 4'(RECOV_CYC);
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end

            ST_RECOV: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            last_q   <= IW'(NREQ - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            ce_q     <= 1'b0;
            set_q    <= 1'b0;
            rst_q    <= 1'b0;
            bank_d_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            ce_q     <= ce_d;
            set_q    <= set_d;
            rst_q    <= rst_d;
            bank_d_q <= bank_d_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.bank_ce  = ce_q;
    assign bus.bank_d   = bank_d_q;
    assign bus.bank_set = set_q;
    assign bus.bank_rst = rst_q;

    // The bank cells misbehave if SET/RST overlap each other or CE.
    a_pins_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(set_q && rst_q) && !(ce_q && (set_q || rst_q)));

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_q));

endmodule

// File: tb/tb_fdd_bank_arbiter.sv
// Scoreboard bench for fdd_bank_arbiter: stimulus queues expected grants, a negedge monitor checks them.
module tb_fdd_bank_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int RECOV_CYC = 2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef struct {
        int         idx;
        logic [1:0] op;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fdd_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fdd_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RECOV_CYC(RECOV_CYC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [1:0] o, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.op   = o;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int i, input logic [1:0] o, input logic [7:0] d);
        bus.op[2*i +: 2]       = o;
        bus.wdata[WIDTH*i +: WIDTH] = d;
        bus.req[i]             = 1'b1;
    endtask

    // Requesters release req as soon as their ack is visible unless told to hold.
    task automatic run_cycles(input int n, input bit autodrop);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (autodrop) bus.req = bus.req & ~bus.ack;
        end
    endtask

    // Monitor: pops an expectation on every ack, then checks recovery and idle cycles.
    initial begin
        int         rec_left;
        bit         idle_next;
        logic [7:0] exp_d;
        logic [3:0] hold_gnt;
        int         cyc;
        int         sr_cyc;
        bit         sr_valid;
        exp_t       e;
        rec_left  = 0;
        idle_next = 0;
        exp_d     = '0;
        hold_gnt  = '0;
        cyc       = 0;
        sr_cyc    = 0;
        sr_valid  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rec_left  = 0;
                idle_next = 0;
                exp_d     = '0;
                sr_valid  = 0;
                chk("reset_outputs", {bus.gnt, bus.ack, bus.busy, bus.bank_ce, bus.bank_set,
                                      bus.bank_rst, bus.bank_d}, '0);
            end else begin
                if (rec_left > 0) begin
                    chk("recov_busy", 32'(bus.busy), 32'd1);
                    chk("recov_gnt", 32'(bus.gnt), 32'(hold_gnt));
                    chk("recov_ctrl", {bus.ack, bus.bank_ce, bus.bank_set, bus.bank_rst}, '0);
                    rec_left--;
                    if (rec_left == 0) idle_next = 1;
                end else if (idle_next) begin
                    chk("post_idle", {bus.busy, bus.gnt, bus.ack, bus.bank_ce, bus.bank_set,
                                      bus.bank_rst}, '0);
                    idle_next = 0;
                end else if (bus.ack != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(bus.ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("ack req=%0d op=%0d bank_d=%0h t=%0t", e.idx, e.op, bus.bank_d, $time);
                        if (e.op == OP_LOAD) exp_d = e.data;
                        chk("drive_gnt", 32'(bus.gnt), 32'(1) << e.idx);
                        chk("drive_ack", 32'(bus.ack), 32'(1) << e.idx);
                        chk("drive_busy", 32'(bus.busy), 32'd1);
                        chk("drive_ctrl", {bus.bank_ce, bus.bank_set, bus.bank_rst},
                            {e.op == OP_LOAD, e.op == OP_SET, e.op == OP_CLR});
                        if (e.op == OP_LOAD && sr_valid) begin
                            chk("ce_after_recov", 32'(cyc - sr_cyc >= 2 + RECOV_CYC), 32'd1);
                            sr_valid = 0;
                        end
                        if (e.op == OP_SET || e.op == OP_CLR) begin
                            rec_left = RECOV_CYC;
                            hold_gnt = 4'(1 << e.idx);
                            sr_cyc   = cyc;
                            sr_valid = 1;
                        end else begin
                            idle_next = 1;
                        end
                    end
                end else begin
                    chk("idle_outputs", {bus.busy, bus.gnt, bus.bank_ce, bus.bank_set,
                                         bus.bank_rst}, '0);
                end
                chk("bank_d", 32'(bus.bank_d), 32'(exp_d));
            end
        end
    end

    initial begin
        bus.req   = '0;
        bus.op    = '1;
        bus.wdata = '0;
        rst_n     = 1'b0;

        // Reset, then idle.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        run_cycles(5, 1);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single LOAD from requester 2.
        issue(2, OP_LOAD, 8'hA5);
        push(2, OP_LOAD, 8'hA5);
        run_cycles(4, 1);

        // SET from requester 1, then a LOAD from requester 3 waiting out the recovery gap.
        issue(1, OP_SET, 8'h00);
        push(1, OP_SET, 8'h00);
        run_cycles(1, 1);
        issue(3, OP_LOAD, 8'h3C);
        push(3, OP_LOAD, 8'h3C);
        run_cycles(8, 1);

        // Four simultaneous requests, pointer at 3: order 0,1,2,3 (requester 1 is a NOP).
        issue(0, OP_LOAD, 8'h11);
        issue(1, OP_NOP,  8'h22);
        issue(2, OP_LOAD, 8'h33);
        issue(3, OP_LOAD, 8'h44);
        push(0, OP_LOAD, 8'h11);
        push(1, OP_NOP,  8'h22);
        push(2, OP_LOAD, 8'h33);
        push(3, OP_LOAD, 8'h44);
        run_cycles(10, 1);

        // CLR aborted by reset during recovery; pointer returns to 3 so requester 0 wins next.
        issue(2, OP_CLR, 8'h00);
        push(2, OP_CLR, 8'h00);
        run_cycles(2, 1);
        chk("recov_before_reset", 32'(bus.gnt), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_ctrl", {bus.busy, bus.ack, bus.bank_ce, bus.bank_set, bus.bank_rst}, '0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, OP_LOAD, 8'h55);
        issue(3, OP_LOAD, 8'h66);
        push(0, OP_LOAD, 8'h55);
        push(3, OP_LOAD, 8'h66);
        run_cycles(6, 1);

        // Requesters 0 and 3 hold req continuously for four grants.
        rst_n = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, OP_LOAD, 8'h77);
        issue(3, OP_LOAD, 8'h88);
`ifdef FDD_ARB_PRIO0_EN
        for (int n = 0; n < 4; n++) push(0, OP_LOAD, 8'h77);
`else
        for (int n = 0; n < 2; n++) begin
            push(0, OP_LOAD, 8'h77);
            push(3, OP_LOAD, 8'h88);
        end
`endif
        run_cycles(7, 0);
        bus.req = '0;
        run_cycles(4, 1);

        chk("all_expected_acks_seen", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
